// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: shared types and constants for the MEM-stage exception controller.
//   cp0_op_t    - cp0 write-port operation type
//   exc_info_t  - exception payload written to cp0 (epc, cause.bd, cause.exccode, badvaddr)
//   exc_flags_t - per-instruction exception flags from the pipeline (10 bits)
//   prio_res_t  - result of the exception priority encoder
package exc_ctrl_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned EXCCODE_W  = 5;
   localparam int unsigned STATUS_IE  = 0;
   localparam int unsigned STATUS_EXL = 1;
   localparam int unsigned STATUS_BEV = 22;

   // Exception codes
   localparam logic [EXCCODE_W-1:0] EXC_INT  = 5'd0;
   localparam logic [EXCCODE_W-1:0] EXC_MOD  = 5'd1;
   localparam logic [EXCCODE_W-1:0] EXC_TLBL = 5'd2;
   localparam logic [EXCCODE_W-1:0] EXC_TLBS = 5'd3;
   localparam logic [EXCCODE_W-1:0] EXC_ADEL = 5'd4;
   localparam logic [EXCCODE_W-1:0] EXC_ADES = 5'd5;
   localparam logic [EXCCODE_W-1:0] EXC_SYS  = 5'd8;
   localparam logic [EXCCODE_W-1:0] EXC_BP   = 5'd9;
   localparam logic [EXCCODE_W-1:0] EXC_RI   = 5'd10;
   localparam logic [EXCCODE_W-1:0] EXC_OV   = 5'd12;

   // Exception vector bases and offsets
   localparam logic [XLEN-1:0] VEC_BASE_NORMAL = 32'h8000_0000;
   localparam logic [XLEN-1:0] VEC_BASE_BOOT   = 32'hBFC0_0200;
   localparam logic [XLEN-1:0] VEC_OFF_REFILL  = 32'h0000_0000;
   localparam logic [XLEN-1:0] VEC_OFF_GENERAL = 32'h0000_0180;

   typedef enum logic [2:0] {
      CP0_NONE  = 3'd0,
      CP0_MTC0  = 3'd1,
      CP0_EXC   = 3'd2,
      CP0_BADVA = 3'd3,
      CP0_ERET  = 3'd4,
      CP0_TLB   = 3'd5
   } cp0_op_t;

   typedef struct packed {
      logic [XLEN-1:0]      epc;
      logic                 cause_bd;
      logic [EXCCODE_W-1:0] cause_exccode;
      logic [XLEN-1:0]      badvaddr;
   } exc_info_t;

   // A data access raises at most one fault, so the data side is a 3-bit code
   // carrying both the load/store select and the refill/invalid distinction.
   typedef enum logic [2:0] {
      D_NONE        = 3'd0,
      D_ADEL        = 3'd1,
      D_ADES        = 3'd2,
      D_TLBL_REFILL = 3'd3,
      D_TLBL_INV    = 3'd4,
      D_TLBS_REFILL = 3'd5,
      D_TLBS_INV    = 3'd6,
      D_MOD         = 3'd7
   } d_exc_t;

   typedef struct packed {
      logic   adel_if;
      logic   tlbrefill_if;
      logic   tlbinv_if;
      logic   ri;
      logic   ov;
      logic   sys;
      logic   bp;
      d_exc_t d_exc;
   } exc_flags_t;

   typedef struct packed {
      logic                 valid;
      logic [EXCCODE_W-1:0] exccode;
      cp0_op_t              wtype;
      logic                 badva_dvaddr;   // 1: badvaddr from data address, 0: from pc
      logic                 is_refill;
   } prio_res_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SETTLE = 2'd2
   } exc_state_t;

   // Refill goes to the base only when not already at exception level.
   function automatic logic [XLEN-1:0] exc_vector(input logic bev, input logic exl,
                                                   input logic is_refill);
      logic [XLEN-1:0] base;
      base = bev ? VEC_BASE_BOOT : VEC_BASE_NORMAL;
      return (is_refill && !exl) ? (base + VEC_OFF_REFILL) : (base + VEC_OFF_GENERAL);
   endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: MEM-stage request, cp0 snapshot/handshake and controller outputs.
//   slave  - the exception controller view
//   master - the pipeline/cp0 environment view
interface exc_ctrl_if;
   import exc_ctrl_pkg::*;

   logic        m_valid;
   logic [31:0] m_pc;
   logic        m_is_bd;
   exc_flags_t  m_exc_flags;
   logic [31:0] m_dvaddr;
   logic        m_eret;
   logic        m_mtc0;
   logic [7:0]  m_cp0_addr;
   logic [31:0] m_cp0_wdata;
   logic [31:0] cp0_status;
   logic [31:0] cp0_cause;
   logic [31:0] cp0_epc;
   logic        cp0_ready;

   logic        cp0_wen;
   cp0_op_t     cp0_wtype;
   exc_info_t   cp0_exc_info;
   logic [4:0]  cp0_waddr;
   logic [2:0]  cp0_wsel;
   logic [31:0] cp0_wdata;
   logic        busy;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport slave (
      input  m_valid, m_pc, m_is_bd, m_exc_flags, m_dvaddr, m_eret, m_mtc0,
             m_cp0_addr, m_cp0_wdata, cp0_status, cp0_cause, cp0_epc, cp0_ready,
      output cp0_wen, cp0_wtype, cp0_exc_info, cp0_waddr, cp0_wsel, cp0_wdata,
             busy, flush, redirect_valid, redirect_pc
   );

   modport master (
      output m_valid, m_pc, m_is_bd, m_exc_flags, m_dvaddr, m_eret, m_mtc0,
             m_cp0_addr, m_cp0_wdata, cp0_status, cp0_cause, cp0_epc, cp0_ready,
      input  cp0_wen, cp0_wtype, cp0_exc_info, cp0_waddr, cp0_wsel, cp0_wdata,
             busy, flush, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/exc_ctrl_prio_enc.sv
// exc_prio_enc: combinational exception priority encoder.
//   flags    - per-instruction exception flags
//   int_pend - qualified pending interrupt
//   prio_c   - winning exception: valid, exccode, cp0 write type, badvaddr source, refill
module exc_prio_enc
   import exc_ctrl_pkg::*;
(
   input  exc_flags_t flags,
   input  logic       int_pend,
   output prio_res_t  prio_c
);

   always_comb begin
      prio_c       = '0;
      prio_c.wtype = CP0_NONE;
      prio_c.valid = 1'b1;
      if (int_pend) begin
         prio_c.exccode = EXC_INT;
         prio_c.wtype   = CP0_EXC;
      end else if (flags.adel_if) begin
         prio_c.exccode = EXC_ADEL;
         prio_c.wtype   = CP0_BADVA;
      end else if (flags.tlbrefill_if) begin
         prio_c.exccode   = EXC_TLBL;
         prio_c.wtype     = CP0_TLB;
         prio_c.is_refill = 1'b1;
      end else if (flags.tlbinv_if) begin
         prio_c.exccode = EXC_TLBL;
         prio_c.wtype   = CP0_TLB;
      end else if (flags.ri) begin
         prio_c.exccode = EXC_RI;
         prio_c.wtype   = CP0_EXC;
      end else if (flags.ov) begin
         prio_c.exccode = EXC_OV;
         prio_c.wtype   = CP0_EXC;
      end else if (flags.sys) begin
         prio_c.exccode = EXC_SYS;
         prio_c.wtype   = CP0_EXC;
      end else if (flags.bp) begin
         prio_c.exccode = EXC_BP;
         prio_c.wtype   = CP0_EXC;
      end else begin
         prio_c.badva_dvaddr = 1'b1;
         case (flags.d_exc)
            D_ADEL: begin
               prio_c.exccode = EXC_ADEL;
               prio_c.wtype   = CP0_BADVA;
            end
            D_ADES: begin
               prio_c.exccode = EXC_ADES;
               prio_c.wtype   = CP0_BADVA;
            end
            D_TLBL_REFILL: begin
               prio_c.exccode   = EXC_TLBL;
               prio_c.wtype     = CP0_TLB;
               prio_c.is_refill = 1'b1;
            end
            D_TLBL_INV: begin
               prio_c.exccode = EXC_TLBL;
               prio_c.wtype   = CP0_TLB;
            end
            D_TLBS_REFILL: begin
               prio_c.exccode   = EXC_TLBS;
               prio_c.wtype     = CP0_TLB;
               prio_c.is_refill = 1'b1;
            end
            D_TLBS_INV: begin
               prio_c.exccode = EXC_TLBS;
               prio_c.wtype   = CP0_TLB;
            end
            D_MOD: begin
               prio_c.exccode = EXC_MOD;
               prio_c.wtype   = CP0_TLB;
            end
            default: begin
               prio_c.valid        = 1'b0;
               prio_c.badva_dvaddr = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt arbiter at the MEM/commit point; sole writer of cp0.
//   clk, rst - clock, synchronous active-high reset
//   bus      - exc_ctrl_if.slave: MEM request, cp0 snapshots/ready, cp0 write port,
//              busy/flush to the pipeline, redirect_valid/redirect_pc to fetch
// The accept cycle drives cp0/busy/flush straight from the request so the pipeline
// freezes in the same cycle; WAIT replays the captured request until cp0_ready.
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter bit          RESET_BEV    = 1'b1,
   parameter int unsigned DEPTH_SETTLE = 1
) (
   input logic      clk,
   input logic      rst,
   exc_ctrl_if.slave bus
);

   localparam int unsigned SETTLE_W = (DEPTH_SETTLE > 1) ? $clog2(DEPTH_SETTLE) : 1;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST =
      SETTLE_W'((DEPTH_SETTLE == 0) ? 0 : (DEPTH_SETTLE - 1));

   exc_state_t          state_q, state_d;
   logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;

   prio_res_t   prio_c;
   logic        int_pend_c;
   logic        accept_c;
   logic [31:0] epc_c;

   cp0_op_t     req_wtype_c;
   exc_info_t   req_info_c;
   logic [4:0]  req_waddr_c;
   logic [2:0]  req_wsel_c;
   logic [31:0] req_wdata_c;
   logic [31:0] req_rpc_c;
   logic        req_is_mtc0_c;

   cp0_op_t     wtype_q;
   exc_info_t   info_q;
   logic [4:0]  waddr_q;
   logic [2:0]  wsel_q;
   logic [31:0] wdata_q;
   logic        is_mtc0_q;
   logic [31:0] rpc_q;
   logic        redir_q;

   logic        wen_c, busy_c, flush_c;
   cp0_op_t     wtype_c;
   exc_info_t   info_c;
   logic [4:0]  waddr_c;
   logic [2:0]  wsel_c;
   logic [31:0] wdata_c;

   // Snapshots are only trusted in IDLE once the settle window has drained.
   assign int_pend_c = bus.cp0_status[STATUS_IE] & ~bus.cp0_status[STATUS_EXL]
                     & (|(bus.cp0_cause[15:8] & bus.cp0_status[15:8]))
                     & (state_q == ST_IDLE) & (settle_cnt_q == '0);

   exc_prio_enc u_prio (
      .flags    (bus.m_exc_flags),
      .int_pend (int_pend_c),
      .prio_c   (prio_c)
   );

   assign epc_c    = bus.m_is_bd ? (bus.m_pc - 32'd4) : bus.m_pc;
   assign accept_c = ~rst & (state_q == ST_IDLE) & bus.m_valid
                   & (prio_c.valid | bus.m_eret | bus.m_mtc0);

   // Request decode; an exception masks ERET/MTC0 of the same instruction.
   always_comb begin
      req_wtype_c   = CP0_NONE;
      req_info_c    = '0;
      req_waddr_c   = '0;
      req_wsel_c    = '0;
      req_wdata_c   = '0;
      req_rpc_c     = '0;
      req_is_mtc0_c = 1'b0;
      if (prio_c.valid) begin
         req_wtype_c              = prio_c.wtype;
         req_info_c.epc           = epc_c;
         req_info_c.cause_bd      = bus.m_is_bd;
         req_info_c.cause_exccode = prio_c.exccode;
         if (prio_c.wtype == CP0_BADVA || prio_c.wtype == CP0_TLB)
            req_info_c.badvaddr = prio_c.badva_dvaddr ? bus.m_dvaddr : bus.m_pc;
         req_rpc_c = exc_vector(bus.cp0_status[STATUS_BEV], bus.cp0_status[STATUS_EXL],
                                prio_c.is_refill);
      end else if (bus.m_eret) begin
         req_wtype_c = CP0_ERET;
         req_rpc_c   = bus.cp0_epc;
      end else if (bus.m_mtc0) begin
         req_wtype_c   = CP0_MTC0;
         req_waddr_c   = bus.m_cp0_addr[4:0];
         req_wsel_c    = bus.m_cp0_addr[7:5];
         req_wdata_c   = bus.m_cp0_wdata;
         req_is_mtc0_c = 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         settle_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
      end
   end

   // FSM next state and cp0/pipeline outputs
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      wen_c        = 1'b0;
      busy_c       = 1'b0;
      flush_c      = 1'b0;
      wtype_c      = CP0_NONE;
      info_c       = '0;
      waddr_c      = '0;
      wsel_c       = '0;
      wdata_c      = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               state_d = ST_WAIT;
               wen_c   = 1'b1;
               busy_c  = 1'b1;
               flush_c = ~req_is_mtc0_c;
               wtype_c = req_wtype_c;
               info_c  = req_info_c;
               waddr_c = req_waddr_c;
               wsel_c  = req_wsel_c;
               wdata_c = req_wdata_c;
            end
         end
         ST_WAIT: begin
            wen_c   = 1'b1;
            busy_c  = 1'b1;
            wtype_c = wtype_q;
            info_c  = info_q;
            waddr_c = waddr_q;
            wsel_c  = wsel_q;
            wdata_c = wdata_q;
            if (bus.cp0_ready) begin
               settle_cnt_d = '0;
               state_d      = (DEPTH_SETTLE == 0) ? ST_IDLE : ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            busy_c = 1'b1;
            if (settle_cnt_q == SETTLE_LAST) begin
               settle_cnt_d = '0;
               state_d      = ST_IDLE;
            end else begin
               settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Captured request and redirect pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         wtype_q   <= CP0_NONE;
         info_q    <= '0;
         waddr_q   <= '0;
         wsel_q    <= '0;
         wdata_q   <= '0;
         is_mtc0_q <= 1'b0;
         rpc_q     <= '0;
         redir_q   <= 1'b0;
      end else begin
         redir_q <= (state_q == ST_WAIT) & bus.cp0_ready & ~is_mtc0_q;
         if (accept_c) begin
            wtype_q   <= req_wtype_c;
            info_q    <= req_info_c;
            waddr_q   <= req_waddr_c;
            wsel_q    <= req_wsel_c;
            wdata_q   <= req_wdata_c;
            is_mtc0_q <= req_is_mtc0_c;
            rpc_q     <= req_rpc_c;
         end
      end
   end

   assign bus.cp0_wen        = wen_c;
   assign bus.cp0_wtype      = wtype_c;
   assign bus.cp0_exc_info   = info_c;
   assign bus.cp0_waddr      = waddr_c;
   assign bus.cp0_wsel       = wsel_c;
   assign bus.cp0_wdata      = wdata_c;
   assign bus.busy           = busy_c;
   assign bus.flush          = flush_c;
   assign bus.redirect_valid = redir_q;
   assign bus.redirect_pc    = rpc_q;

   logic unused_snapshot_bits;
   assign unused_snapshot_bits = ^{bus.cp0_status[31:23], bus.cp0_status[21:16],
                                   bus.cp0_status[7:2], bus.cp0_cause[31:16],
                                   bus.cp0_cause[7:0]};

   // Status.BEV must read as the reset value in the first cycle after reset.
   logic rst_q;
   always_ff @(posedge clk) rst_q <= rst;

   a_reset_bev: assert property (@(posedge clk)
      (rst_q && !rst) |-> (bus.cp0_status[STATUS_BEV] == RESET_BEV));

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed self-checking bench for exc_ctrl with a 3-cycle cp0 write model.
module tb_exc_ctrl;
   import exc_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   exc_ctrl_if bus ();

   exc_ctrl #(
      .RESET_BEV    (1'b1),
      .DEPTH_SETTLE (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_req();
      bus.m_valid     = 1'b0;
      bus.m_is_bd     = 1'b0;
      bus.m_exc_flags = '0;
      bus.m_eret      = 1'b0;
      bus.m_mtc0      = 1'b0;
   endtask

   // Inputs for the accept cycle are already applied; walks accept, two WAIT cycles
   // (cp0_ready on the third wen cycle) and returns at the SETTLE sample point.
   task automatic run_txn(input string tag, input logic exp_flush, input logic exp_redir,
                          input cp0_op_t exp_wtype, input logic [4:0] exp_code,
                          input logic [31:0] exp_epc, input logic exp_bd,
                          input logic [31:0] exp_bva, input logic [4:0] exp_waddr,
                          input logic [2:0] exp_wsel, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rpc);
      @(negedge clk);
      check_val({tag, "/acc_wen"},   32'(bus.cp0_wen), 32'd1);
      check_val({tag, "/acc_busy"},  32'(bus.busy), 32'd1);
      check_val({tag, "/acc_flush"}, 32'(bus.flush), 32'(exp_flush));
      check_val({tag, "/wtype"},     32'(bus.cp0_wtype), 32'(exp_wtype));
      check_val({tag, "/exccode"},   32'(bus.cp0_exc_info.cause_exccode), 32'(exp_code));
      check_val({tag, "/epc"},       bus.cp0_exc_info.epc, exp_epc);
      check_val({tag, "/bd"},        32'(bus.cp0_exc_info.cause_bd), 32'(exp_bd));
      check_val({tag, "/badvaddr"},  bus.cp0_exc_info.badvaddr, exp_bva);
      check_val({tag, "/waddr"},     32'(bus.cp0_waddr), 32'(exp_waddr));
      check_val({tag, "/wsel"},      32'(bus.cp0_wsel), 32'(exp_wsel));
      check_val({tag, "/wdata"},     bus.cp0_wdata, exp_wdata);
      @(posedge clk); #1;
      clear_req();
      @(negedge clk);
      check_val({tag, "/w1_wen"},   32'(bus.cp0_wen), 32'd1);
      check_val({tag, "/w1_wtype"}, 32'(bus.cp0_wtype), 32'(exp_wtype));
      check_val({tag, "/w1_epc"},   bus.cp0_exc_info.epc, exp_epc);
      check_val({tag, "/w1_flush"}, 32'(bus.flush), 32'd0);
      check_val({tag, "/w1_rv"},    32'(bus.redirect_valid), 32'd0);
      @(posedge clk); #1;
      bus.cp0_ready = 1'b1;
      @(negedge clk);
      check_val({tag, "/w2_wen"}, 32'(bus.cp0_wen), 32'd1);
      @(posedge clk); #1;
      bus.cp0_ready = 1'b0;
      @(negedge clk);
      check_val({tag, "/s_wen"},  32'(bus.cp0_wen), 32'd0);
      check_val({tag, "/s_busy"}, 32'(bus.busy), 32'd1);
      check_val({tag, "/s_rv"},   32'(bus.redirect_valid), 32'(exp_redir));
      if (exp_redir) check_val({tag, "/rpc"}, bus.redirect_pc, exp_rpc);
   endtask

   task automatic idle_check(input string tag);
      @(posedge clk); #1;
      @(negedge clk);
      check_val({tag, "/idle_busy"}, 32'(bus.busy), 32'd0);
      check_val({tag, "/idle_rv"},   32'(bus.redirect_valid), 32'd0);
      check_val({tag, "/idle_wen"},  32'(bus.cp0_wen), 32'd0);
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      rst             = 1'b1;
      clear_req();
      bus.m_pc        = '0;
      bus.m_dvaddr    = '0;
      bus.m_cp0_addr  = '0;
      bus.m_cp0_wdata = '0;
      bus.cp0_status  = 32'h0040_0000;
      bus.cp0_cause   = '0;
      bus.cp0_epc     = '0;
      bus.cp0_ready   = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst/wen",   32'(bus.cp0_wen), 32'd0);
      check_val("rst/busy",  32'(bus.busy), 32'd0);
      check_val("rst/flush", 32'(bus.flush), 32'd0);
      check_val("rst/rv",    32'(bus.redirect_valid), 32'd0);
      check_val("rst/wtype", 32'(bus.cp0_wtype), 32'(CP0_NONE));
      check_val("rst/rpc",   bus.redirect_pc, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // cp0_ready in IDLE is ignored
      @(negedge clk);
      bus.cp0_ready = 1'b1;
      #1;
      check_val("rdy_idle/wen",  32'(bus.cp0_wen), 32'd0);
      check_val("rdy_idle/busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      bus.cp0_ready = 1'b0;
      @(negedge clk);
      check_val("rdy_idle/rv",   32'(bus.redirect_valid), 32'd0);
      check_val("rdy_idle/busy2", 32'(bus.busy), 32'd0);

      // Syscall, BEV=1
      @(posedge clk); #1;
      bus.m_valid         = 1'b1;
      bus.m_pc            = 32'hBFC0_0100;
      bus.m_exc_flags.sys = 1'b1;
      run_txn("sys", 1'b1, 1'b1, CP0_EXC, 5'd8, 32'hBFC0_0100, 1'b0, 32'd0,
              5'd0, 3'd0, 32'd0, 32'hBFC0_0380);
      idle_check("sys");

      // Data AdEL in a delay slot, BEV=0; same-instruction ERET is suppressed
      @(posedge clk); #1;
      bus.cp0_status        = 32'h0000_0000;
      bus.cp0_epc           = 32'h1234_5678;
      bus.m_valid           = 1'b1;
      bus.m_pc              = 32'h8000_1004;
      bus.m_is_bd           = 1'b1;
      bus.m_dvaddr          = 32'h0000_0003;
      bus.m_exc_flags.d_exc = D_ADEL;
      bus.m_eret            = 1'b1;
      run_txn("adel_d", 1'b1, 1'b1, CP0_BADVA, 5'd4, 32'h8000_1000, 1'b1, 32'h0000_0003,
              5'd0, 3'd0, 32'd0, 32'h8000_0180);
      idle_check("adel_d");

      // Fetch TLB refill, EXL=0 -> refill vector
      @(posedge clk); #1;
      bus.m_valid                  = 1'b1;
      bus.m_pc                     = 32'h0040_0000;
      bus.m_exc_flags.tlbrefill_if = 1'b1;
      run_txn("tlbr_exl0", 1'b1, 1'b1, CP0_TLB, 5'd2, 32'h0040_0000, 1'b0, 32'h0040_0000,
              5'd0, 3'd0, 32'd0, 32'h8000_0000);
      idle_check("tlbr_exl0");

      // Fetch TLB refill, EXL=1 -> general vector
      @(posedge clk); #1;
      bus.cp0_status               = 32'h0000_0002;
      bus.m_valid                  = 1'b1;
      bus.m_pc                     = 32'h0040_0000;
      bus.m_exc_flags.tlbrefill_if = 1'b1;
      run_txn("tlbr_exl1", 1'b1, 1'b1, CP0_TLB, 5'd2, 32'h0040_0000, 1'b0, 32'h0040_0000,
              5'd0, 3'd0, 32'd0, 32'h8000_0180);
      idle_check("tlbr_exl1");

      // Interrupt beats a concurrent overflow
      @(posedge clk); #1;
      bus.cp0_status     = 32'h0000_FF01;
      bus.cp0_cause      = 32'h0000_0400;
      bus.m_valid        = 1'b1;
      bus.m_pc           = 32'h8000_3000;
      bus.m_exc_flags.ov = 1'b1;
      run_txn("int_ov", 1'b1, 1'b1, CP0_EXC, 5'd0, 32'h8000_3000, 1'b0, 32'd0,
              5'd0, 3'd0, 32'd0, 32'h8000_0180);
      idle_check("int_ov");

      // Breakpoint with interrupts masked by EXL, then an interrupt appears in SETTLE
      @(posedge clk); #1;
      bus.cp0_status     = 32'h0000_FF03;
      bus.m_valid        = 1'b1;
      bus.m_pc           = 32'h8000_4000;
      bus.m_exc_flags.bp = 1'b1;
      run_txn("bp", 1'b1, 1'b1, CP0_EXC, 5'd9, 32'h8000_4000, 1'b0, 32'd0,
              5'd0, 3'd0, 32'd0, 32'h8000_0180);
      #1;
      bus.cp0_status = 32'h0000_FF01;
      bus.m_valid    = 1'b1;
      bus.m_pc       = 32'h8000_5000;
      #1;
      check_val("int_settle/wen",  32'(bus.cp0_wen), 32'd0);
      check_val("int_settle/busy", 32'(bus.busy), 32'd1);
      run_txn("int_idle", 1'b1, 1'b1, CP0_EXC, 5'd0, 32'h8000_5000, 1'b0, 32'd0,
              5'd0, 3'd0, 32'd0, 32'h8000_0180);
      idle_check("int_idle");

      // MTC0 EPC immediately followed by ERET
      @(posedge clk); #1;
      bus.cp0_status  = 32'h0000_0000;
      bus.cp0_cause   = 32'h0000_0000;
      bus.m_valid     = 1'b1;
      bus.m_pc        = 32'h8000_6000;
      bus.m_mtc0      = 1'b1;
      bus.m_cp0_addr  = 8'h0E;
      bus.m_cp0_wdata = 32'h8000_2000;
      run_txn("mtc0", 1'b0, 1'b0, CP0_MTC0, 5'd0, 32'd0, 1'b0, 32'd0,
              5'd14, 3'd0, 32'h8000_2000, 32'd0);
      #1;
      bus.cp0_epc = 32'h8000_2000;
      bus.m_valid = 1'b1;
      bus.m_pc    = 32'h8000_6004;
      bus.m_eret  = 1'b1;
      #1;
      check_val("eret_settle/wen",  32'(bus.cp0_wen), 32'd0);
      check_val("eret_settle/busy", 32'(bus.busy), 32'd1);
      run_txn("eret", 1'b1, 1'b1, CP0_ERET, 5'd0, 32'd0, 1'b0, 32'd0,
              5'd0, 3'd0, 32'd0, 32'h8000_2000);
      idle_check("eret");

      // Reset in the second WAIT cycle
      @(posedge clk); #1;
      bus.cp0_status      = 32'h0040_0000;
      bus.m_valid         = 1'b1;
      bus.m_pc            = 32'hBFC0_0200;
      bus.m_exc_flags.sys = 1'b1;
      @(negedge clk);
      check_val("rst_wait/acc_wen", 32'(bus.cp0_wen), 32'd1);
      @(posedge clk); #1;
      clear_req();
      @(posedge clk); #1;
      rst           = 1'b1;
      bus.cp0_ready = 1'b1;
      @(posedge clk); #1;
      rst           = 1'b0;
      bus.cp0_ready = 1'b0;
      @(negedge clk);
      check_val("rst_wait/wen",  32'(bus.cp0_wen), 32'd0);
      check_val("rst_wait/busy", 32'(bus.busy), 32'd0);
      check_val("rst_wait/rv",   32'(bus.redirect_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("rst_wait/rv2",   32'(bus.redirect_valid), 32'd0);
      check_val("rst_wait/busy2", 32'(bus.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt arbiter at the MEM/commit point of the pipeline; sole owner of the cp0_regfile write port.
- Prioritises per-instruction exception flags and pending interrupts, handles ERET and MTC0, and drives cp0 wen/wtype/exc_info/waddr/wsel/wdata through cp0's multi-cycle ready handshake.
- Issues pipeline flush and PC redirect to the exception vector or EPC.

Parameters:
- RESET_BEV, 1, expected Status.BEV after reset; documentation and assertion check only.
- DEPTH_SETTLE, 1, idle cycles after a cp0 write before the cp0 status/cause/epc snapshots are trusted again.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_valid  in  1  instruction in MEM is valid and not being stalled by memory
- m_pc  in  32  PC of that instruction
- m_is_bd  in  1  instruction sits in a branch delay slot
- m_exc_flags  in  10  {adel_if, tlbrefill_if, tlbinv_if, ri, ov, sys, bp, adel_d/ades_d sel, tlb_d (refill/inv), mod}, encoded as a packed struct
- m_dvaddr  in  32  data virtual address
- m_eret  in  1  ERET in MEM
- m_mtc0  in  1  MTC0 in MEM
- m_cp0_addr  in  8  {sel, rd}
- m_cp0_wdata  in  32  MTC0 data
- cp0_status  in  32  cp0 snapshot
- cp0_cause  in  32  cp0 snapshot
- cp0_epc  in  32  cp0 snapshot
- cp0_ready  in  1  cp0 handshake
- cp0_wen  out  1  cp0 write enable
- cp0_wtype  out  cp0_op_t  NONE/MTC0/EXC/BADVA/ERET/TLB
- cp0_exc_info  out  exc_info_t  epc, cause_bd, cause_exccode, badvaddr
- cp0_waddr  out  5  write address
- cp0_wsel  out  3  write select
- cp0_wdata  out  32  write data
- busy  out  1  stall MEM and all older stages
- flush  out  1  kill IF..EX
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  32  new fetch PC

Behaviour:
- Reset: state=IDLE; all outputs 0; cp0_wtype=NONE; settle counter=0.
- int_pend = status[0] & ~status[1] & |(cause[15:8] & status[15:8]). Evaluated only in IDLE with settle counter 0.
- Priority, high to low:
  - Int(0)
  - AdEL fetch(4), badvaddr=m_pc
  - TLBL fetch(2), badvaddr=m_pc
  - RI(10), Ov(12), Sys(8), Bp(9), in that order
  - AdEL/AdES data(4/5), badvaddr=m_dvaddr
  - TLBL/TLBS data(2/3)
  - Mod(1)
- Mapping to cp0_wtype:
  - Int/RI/Ov/Sys/Bp -> EXC
  - AdE* -> BADVA
  - TLB*/Mod -> TLB
- Any exception suppresses m_eret and m_mtc0 of the same instruction.
- epc = m_is_bd ? m_pc-4 : m_pc; cause_bd = m_is_bd.
- Vector selection:
  - BEV=status[22]; base = BEV ? 0xBFC00200 : 0x80000000.
  - TLB refill with status[1]==0 -> base+0x000.
  - Everything else -> base+0x180.
  - ERET -> cp0_epc.
- FSM:
  - IDLE: accept when m_valid & (exc | int_pend | m_eret | m_mtc0). In the accept cycle: assert cp0_wen, drive wtype/exc_info/addr/data, busy=1; flush=1 unless MTC0. Capture redirect_pc in a register. Go WAIT.
  - WAIT: hold all cp0_* outputs stable, busy=1. On cp0_ready: drop cp0_wen next cycle. Pulse redirect_valid for exactly that one cycle unless MTC0. Go SETTLE.
  - SETTLE: busy=1 for DEPTH_SETTLE cycles, then IDLE. This guarantees cp0 snapshots (which update only while wen=0) are fresh before the next int_pend or ERET evaluation.
- cp0_ready asserted in IDLE is ignored.
- cp0 latency: two cycles after wen rises. The bench models cp0_ready as high on the third wen cycle.
- m_valid deasserting during WAIT/SETTLE has no effect; the request is already captured.
- Reset mid-WAIT: immediate IDLE, wen=0, no redirect.

Decomposition:
- Shared constants belong in cpu_defs.svh: exccode constants (EXC_INT..EXC_OV), vector offsets, exc_flags_t packed struct; existing cp0_op_t and exc_info_t are reused.
- Sub-module exc_prio_enc: purely combinational, flags+int_pend -> {exccode, wtype, badvaddr_sel, is_refill}.

Test Plan:
- Sys at pc=0xBFC00100, bd=0, BEV=1 -> wtype=EXC, exccode=8, epc=0xBFC00100; wen held until cp0_ready; redirect_pc=0xBFC00380 pulses once; flush on the accept cycle.
- AdEL data, dvaddr=0x00000003, bd=1, pc=0x80001004, BEV=0 -> wtype=BADVA, epc=0x80001000, cause_bd=1, badvaddr=0x3, redirect=0x80000180.
- TLBL refill fetch, status[1]=0, BEV=0 -> wtype=TLB, exccode=2, redirect=0x80000000; repeat with status[1]=1 -> redirect=0x80000180.
- status=0x0000FF01, cause[10]=1, with a concurrent Ov -> exccode=0 (Int wins). Repeat during SETTLE -> not taken until IDLE.
- MTC0 EPC=0x80002000 immediately followed by ERET -> ERET is accepted only after SETTLE; redirect_pc=0x80002000; wtype=ERET.
- rst asserted in the 2nd WAIT cycle -> next cycle wen=0, busy=0, no redirect_valid pulse.
